// File: rtl/pushbutton_conditioner_pkg.sv
// Shared constants for the pushbutton conditioner: channel count, debounce defaults
// and a ceil-log2 helper used to size the debounce counter.
package pb_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int NUM_BTN         = 4;
  localparam int DEBOUNCE_CYCLES = 16;
  // Smallest width with 2**CNT_W > DEBOUNCE_CYCLES (5 for the default of 16).
  localparam int CNT_W           = clog2(DEBOUNCE_CYCLES + 1);

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Button bus between the raw pads / core read strobe and the conditioned outputs
// that feed the core pushbuttons port.
import pb_pkg::*;

interface pushbutton_conditioner_if #(
  parameter int NUM_BTN = pb_pkg::NUM_BTN
);
  logic [NUM_BTN-1:0] btn_raw;
  logic               rd_strobe;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] btn_out;

  modport master (
    output btn_raw, rd_strobe,
    input  btn_level, press_pulse, btn_out
  );

  modport slave (
    input  btn_raw, rd_strobe,
    output btn_level, press_pulse, btn_out
  );
endinterface

// File: rtl/pushbutton_conditioner_debounce.sv
// One button channel: two-FF synchroniser, stability counter, debounced level
// and a registered press pulse coincident with the level rising.
import pb_pkg::*;

module pb_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = pb_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = pb_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Everything clears on reset so an in-flight debounce is abandoned without a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      pulse   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        pulse <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions the board pushbuttons for the core IN instruction.
// Define PB_STICKY_EN to latch each press until the core reads it (rd_strobe).
import pb_pkg::*;

module pushbutton_conditioner #(
  parameter int NUM_BTN         = pb_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = pb_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = pb_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  pushbutton_conditioner_if.slave  bus
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    pb_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[i]),
      .level (bus.btn_level[i]),
      .pulse (bus.press_pulse[i])
    );
  end

`ifdef PB_STICKY_EN
  logic [NUM_BTN-1:0] sticky;

  // A press landing on the same edge as the read survives so it is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~{NUM_BTN{bus.rd_strobe}}) | bus.press_pulse;
    end
  end

  assign bus.btn_out = sticky;
`else
  logic unused_rd_strobe;
  assign unused_rd_strobe = bus.rd_strobe;
  assign bus.btn_out      = bus.btn_level;
`endif

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner at DEBOUNCE_CYCLES=4, CNT_W=3.
// Expectations for btn_out follow PB_STICKY_EN when it is defined.
module tb_pushbutton_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pushbutton_conditioner_if #(.NUM_BTN(4)) bus ();

  pushbutton_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_raw   = 4'h0;
    bus.rd_strobe = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.btn_raw   = 4'h0;
    bus.rd_strobe = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.btn_raw = 4'hF;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.btn_level !== 4'hF) begin
      failures++;
      $display("FAIL reset_pre_level: got %h expected %h", bus.btn_level, 4'hF);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.btn_level, bus.press_pulse, bus.btn_out} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async: level %h pulse %h out %h, expected all 0",
               bus.btn_level, bus.press_pulse, bus.btn_out);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({bus.btn_level, bus.press_pulse, bus.btn_out} !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold edge %0d: level %h pulse %h out %h, expected all 0",
                 i, bus.btn_level, bus.press_pulse, bus.btn_out);
      end
    end
    do_reset();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_out;
    bus.btn_raw = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (bus.btn_level !== 4'h0 || bus.press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL press_early edge %0d: level %h pulse %h, expected 0 0",
                 i, bus.btn_level, bus.press_pulse);
      end
    end
    tick();
    checks++;
    if (bus.btn_level !== 4'b0001 || bus.press_pulse !== 4'b0001) begin
      failures++;
      $display("FAIL press_edge6: level %h pulse %h, expected 1 1",
               bus.btn_level, bus.press_pulse);
    end
    tick();
    checks++;
    if (bus.btn_level !== 4'b0001 || bus.press_pulse !== 4'h0 || bus.btn_out !== 4'b0001) begin
      failures++;
      $display("FAIL press_edge7: level %h pulse %h out %h, expected 1 0 1",
               bus.btn_level, bus.press_pulse, bus.btn_out);
    end
    bus.btn_raw = 4'h0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (bus.press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL release_pulse edge %0d: pulse %h expected 0", i, bus.press_pulse);
      end
    end
`ifdef PB_STICKY_EN
    exp_out = 4'b0001;
`else
    exp_out = 4'b0000;
`endif
    checks++;
    if (bus.btn_level !== 4'h0 || bus.btn_out !== exp_out) begin
      failures++;
      $display("FAIL release_level: level %h out %h, expected 0 %h",
               bus.btn_level, bus.btn_out, exp_out);
    end
    do_reset();
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    pattern = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      bus.btn_raw = {2'b00, pattern[i], 1'b0};
      tick();
      checks++;
      if (bus.btn_level !== 4'h0 || bus.press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL bounce_toggle %0d: level %h pulse %h, expected 0 0",
                 i, bus.btn_level, bus.press_pulse);
      end
    end
    bus.btn_raw = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (bus.btn_level !== 4'h0 || bus.press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL bounce_hold edge %0d: level %h pulse %h, expected 0 0",
                 i, bus.btn_level, bus.press_pulse);
      end
    end
    tick();
    checks++;
    if (bus.btn_level !== 4'b0010 || bus.press_pulse !== 4'b0010) begin
      failures++;
      $display("FAIL bounce_accept: level %h pulse %h, expected 2 2",
               bus.btn_level, bus.press_pulse);
    end
    tick();
    checks++;
    if (bus.press_pulse !== 4'h0) begin
      failures++;
      $display("FAIL bounce_single: pulse %h expected 0", bus.press_pulse);
    end
    do_reset();
  endtask

  task automatic test_glitch();
    bus.btn_raw = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    bus.btn_raw = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (bus.btn_level !== 4'h0 || bus.press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL glitch3 edge %0d: level %h pulse %h, expected 0 0",
                 i, bus.btn_level, bus.press_pulse);
      end
    end
    // Exactly DEBOUNCE_CYCLES high samples is the shortest accepted press.
    bus.btn_raw = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    bus.btn_raw = 4'h0;
    tick();
    checks++;
    if (bus.btn_level !== 4'h0) begin
      failures++;
      $display("FAIL glitch4_early: level %h expected 0", bus.btn_level);
    end
    tick();
    checks++;
    if (bus.btn_level !== 4'b0100 || bus.press_pulse !== 4'b0100) begin
      failures++;
      $display("FAIL glitch4_accept: level %h pulse %h, expected 4 4",
               bus.btn_level, bus.press_pulse);
    end
    do_reset();
  endtask

  task automatic test_sticky();
    logic [3:0] exp_out;
    bus.btn_raw = 4'b1000;
    for (int i = 0; i < 8; i++) tick();
    bus.btn_raw = 4'h0;
    for (int i = 0; i < 20; i++) tick();
`ifdef PB_STICKY_EN
    exp_out = 4'b1000;
`else
    exp_out = 4'b0000;
`endif
    checks++;
    if (bus.btn_out !== exp_out) begin
      failures++;
      $display("FAIL sticky_held: out %h expected %h", bus.btn_out, exp_out);
    end
    bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0;
    checks++;
    if (bus.btn_out !== 4'h0) begin
      failures++;
      $display("FAIL sticky_read: out %h expected 0", bus.btn_out);
    end
    do_reset();
  endtask

  task automatic test_collision();
    logic [3:0] exp_out;
    bus.btn_raw = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.press_pulse !== 4'b0001) begin
      failures++;
      $display("FAIL collide_pulse: pulse %h expected 1", bus.press_pulse);
    end
    bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0;
    checks++;
    if (bus.btn_out !== 4'b0001) begin
      failures++;
      $display("FAIL collide_set_wins: out %h expected 1", bus.btn_out);
    end
    tick();
    bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0;
`ifdef PB_STICKY_EN
    exp_out = 4'b0000;
`else
    exp_out = 4'b0001;
`endif
    checks++;
    if (bus.btn_out !== exp_out || bus.btn_level !== 4'b0001) begin
      failures++;
      $display("FAIL collide_read: out %h level %h, expected %h 1",
               bus.btn_out, bus.btn_level, exp_out);
    end
    do_reset();
  endtask

  initial begin
    bus.btn_raw   = 4'h0;
    bus.rd_strobe = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_sticky();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
